// File: rtl/vram_arbiter_if.sv
// Bus bundle between the video/CPU requesters, the arbiter and the bitmap RAM.
// Handshakes: vid_req is a one-cycle strobe with no backpressure, answered by a
// vid_valid pulse; cpu_req is a level held until the one-cycle cpu_ack pulse.
interface vram_arbiter_if #(
   parameter int AW = 15
);
   logic          vid_req;
   logic [AW-1:0] vid_addr;
   logic [7:0]    vid_data;
   logic          vid_valid;
   logic          vid_overrun;
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [7:0]    cpu_wdata;
   logic [1:0]    cpu_nib;
   logic          cpu_ack;
   logic [7:0]    cpu_rdata;
   logic [AW-1:0] ram_addr;
   logic          ram_we;
   logic [1:0]    ram_be;
   logic [7:0]    ram_wdata;
   logic [7:0]    ram_rdata;

   modport master (
      output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_nib, ram_rdata,
      input  vid_data, vid_valid, vid_overrun, cpu_ack, cpu_rdata,
             ram_addr, ram_we, ram_be, ram_wdata
   );

   modport slave (
      input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_nib, ram_rdata,
      output vid_data, vid_valid, vid_overrun, cpu_ack, cpu_rdata,
             ram_addr, ram_we, ram_be, ram_wdata
   );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video fetches win over the CPU, with a one-deep
// video pending buffer and a starvation counter that forces a CPU grant.
module vram_arbiter #(
   parameter int AW     = 15,
   parameter int STARVE = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   vram_arbiter_if.slave        bus,
   output logic [1:0]           dbg_cpu_state
);

   localparam int SW = (STARVE < 1) ? 1 : $clog2(STARVE + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE);

   typedef enum logic [1:0] {C_IDLE, C_WAIT, C_ISSUED, C_DONE} cpu_state_e;

   cpu_state_e    state_q, state_d;
   logic [SW-1:0] starve_q, starve_d;
   logic          pend_v_q, pend_v_d;
   logic [AW-1:0] pend_addr_q, pend_addr_d;
   logic          p1_vid_q, p1_vid_d, p2_vid_q, p2_vid_d;
   logic          p1_crd_q, p1_crd_d, p2_crd_q, p2_crd_d;
   logic          lat_we_q, lat_we_d;
   logic [AW-1:0] ram_addr_q, ram_addr_d;
   logic          ram_we_q, ram_we_d;
   logic [1:0]    ram_be_q, ram_be_d;
   logic [7:0]    ram_wdata_q, ram_wdata_d;
   logic [7:0]    vid_data_q, vid_data_d;
   logic          vid_valid_q, vid_valid_d;
   logic          overrun_q, overrun_d;
   logic          cpu_ack_q, cpu_ack_d;
   logic [7:0]    cpu_rdata_q, cpu_rdata_d;

   logic          cpu_wait, force_cpu, grant_cpu, vid_grant;
   logic [AW-1:0] vid_gaddr;

   always_comb begin
      state_d     = state_q;
      starve_d    = starve_q;
      pend_v_d    = pend_v_q;
      pend_addr_d = pend_addr_q;
      p1_vid_d    = 1'b0;
      p1_crd_d    = 1'b0;
      p2_vid_d    = p1_vid_q;
      p2_crd_d    = p1_crd_q;
      lat_we_d    = lat_we_q;
      ram_addr_d  = ram_addr_q;
      ram_we_d    = 1'b0;
      ram_be_d    = 2'b00;
      ram_wdata_d = ram_wdata_q;
      vid_data_d  = vid_data_q;
      vid_valid_d = 1'b0;
      overrun_d   = overrun_q;
      cpu_ack_d   = 1'b0;
      cpu_rdata_d = cpu_rdata_q;
      grant_cpu   = 1'b0;
      vid_grant   = 1'b0;
      vid_gaddr   = bus.vid_addr;

      cpu_wait  = (state_q == C_WAIT);
      force_cpu = cpu_wait && (starve_q == STARVE_MAX);

      // A forced CPU edge parks a new fetch; a second one with the buffer full is lost.
      if (force_cpu) begin
         grant_cpu = 1'b1;
         if (bus.vid_req) begin
            if (pend_v_q) begin
               overrun_d = 1'b1;
            end else begin
               pend_v_d    = 1'b1;
               pend_addr_d = bus.vid_addr;
            end
         end
      end else if (pend_v_q) begin
         vid_grant   = 1'b1;
         vid_gaddr   = pend_addr_q;
         pend_v_d    = bus.vid_req;
         pend_addr_d = bus.vid_req ? bus.vid_addr : pend_addr_q;
      end else if (bus.vid_req) begin
         vid_grant = 1'b1;
      end else if (cpu_wait) begin
         grant_cpu = 1'b1;
      end

      if (vid_grant) begin
         ram_addr_d = vid_gaddr;
         p1_vid_d   = 1'b1;
      end
      if (grant_cpu) begin
         ram_addr_d  = bus.cpu_addr;
         ram_we_d    = bus.cpu_we;
         ram_be_d    = bus.cpu_we ? bus.cpu_nib : 2'b00;
         ram_wdata_d = bus.cpu_wdata;
         lat_we_d    = bus.cpu_we;
         p1_crd_d    = !bus.cpu_we;
      end

      if (grant_cpu || !cpu_wait) starve_d = '0;
      else                        starve_d = starve_q + SW'(1);

      if (p2_vid_q) begin
         vid_valid_d = 1'b1;
         vid_data_d  = bus.ram_rdata;
      end

      case (state_q)
         C_IDLE:   if (bus.cpu_req) state_d = C_WAIT;
         C_WAIT:   if (grant_cpu) state_d = C_ISSUED;
         C_ISSUED: begin
            // Writes finish one edge after the strobe, reads when RAM data arrives.
            if (lat_we_q || p2_crd_q) begin
               state_d   = C_DONE;
               cpu_ack_d = 1'b1;
               if (!lat_we_q) cpu_rdata_d = bus.ram_rdata;
            end
         end
         default:  state_d = C_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= C_IDLE;
         starve_q    <= '0;
         pend_v_q    <= 1'b0;
         pend_addr_q <= '0;
         p1_vid_q    <= 1'b0;
         p2_vid_q    <= 1'b0;
         p1_crd_q    <= 1'b0;
         p2_crd_q    <= 1'b0;
         lat_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_we_q    <= 1'b0;
         ram_be_q    <= 2'b00;
         ram_wdata_q <= '0;
         vid_data_q  <= '0;
         vid_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
         cpu_ack_q   <= 1'b0;
         cpu_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         pend_v_q    <= pend_v_d;
         pend_addr_q <= pend_addr_d;
         p1_vid_q    <= p1_vid_d;
         p2_vid_q    <= p2_vid_d;
         p1_crd_q    <= p1_crd_d;
         p2_crd_q    <= p2_crd_d;
         lat_we_q    <= lat_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_we_q    <= ram_we_d;
         ram_be_q    <= ram_be_d;
         ram_wdata_q <= ram_wdata_d;
         vid_data_q  <= vid_data_d;
         vid_valid_q <= vid_valid_d;
         overrun_q   <= overrun_d;
         cpu_ack_q   <= cpu_ack_d;
         cpu_rdata_q <= cpu_rdata_d;
      end
   end

   assign bus.vid_data    = vid_data_q;
   assign bus.vid_valid   = vid_valid_q;
   assign bus.vid_overrun = overrun_q;
   assign bus.cpu_ack     = cpu_ack_q;
   assign bus.cpu_rdata   = cpu_rdata_q;
   assign bus.ram_addr    = ram_addr_q;
   assign bus.ram_we      = ram_we_q;
   assign bus.ram_be      = ram_be_q;
   assign bus.ram_wdata   = ram_wdata_q;
   assign dbg_cpu_state   = state_q;

endmodule
